// File: rtl/uart_tx_sched.sv
// Transmit scheduler: buffers host characters in a circular FIFO and drives the
// uart_tx start/ack/done handshake one character per frame.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no frame requested; pops head when enabled, non-empty, tx idle
// REQ       | start_tx_o held high with popped character until acked
// WAIT_DONE | frame in flight; waits for tx_done_i, then back to IDLE
module uart_tx_sched #(
   parameter  int DEPTH = 16,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en_i,
   input  logic [7:0]       wr_data_i,
   input  logic             flush_i,
   input  logic             tx_en_i,
   input  logic             clr_ovf_i,
   input  logic             tx_start_ack_i,
   input  logic             tx_done_i,
   output logic             start_tx_o,
   output logic [31:0]      tx_data_o,
   output logic             fifo_full_o,
   output logic             fifo_empty_o,
   output logic [LVL_W-1:0] fifo_level_o,
   output logic             overflow_o,
   output logic             busy_o,
   output logic             tx_empty_pulse_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

   state_t           state_q, state_n;
   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] count_q, count_n;
   logic [7:0]       data_q;
   logic             start_q, start_n;
   logic             pulse_q, pulse_n;
   logic             ovf_q;
   logic             pop;
   logic             wr_accept;

   assign fifo_empty_o     = (count_q == '0);
   assign fifo_full_o      = (count_q == LVL_W'(DEPTH));
   assign fifo_level_o     = count_q;
   assign overflow_o       = ovf_q;
   assign start_tx_o       = start_q;
   assign tx_data_o        = {24'h0, data_q};
   assign busy_o           = (state_q != IDLE);
   assign tx_empty_pulse_o = pulse_q;

   // A flush drops any concurrent write.
   assign wr_accept = wr_en_i && !fifo_full_o && !flush_i;

   always_comb begin
      state_n = state_q;
      start_n = start_q;
      pulse_n = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_en_i && !fifo_empty_o && tx_done_i && !flush_i) begin
               pop     = 1'b1;
               start_n = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            // An ack in the same cycle as a flush means uart_tx already took the character.
            if (tx_start_ack_i) begin
               start_n = 1'b0;
               state_n = WAIT_DONE;
            end else if (flush_i) begin
               start_n = 1'b0;
               state_n = IDLE;
            end
         end
         WAIT_DONE: begin
            if (tx_done_i) begin
               state_n = IDLE;
               pulse_n = fifo_empty_o || flush_i;
            end
         end
         default: begin
            state_n = IDLE;
            start_n = 1'b0;
         end
      endcase
   end

   always_comb begin
      count_n = count_q;
      if (flush_i) begin
         count_n = '0;
      end else begin
         case ({wr_accept, pop})
            2'b10:   count_n = count_q + LVL_W'(1);
            2'b01:   count_n = count_q - LVL_W'(1);
            default: count_n = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         pulse_q  <= 1'b0;
         ovf_q    <= 1'b0;
         data_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_n;
         start_q <= start_n;
         pulse_q <= pulse_n;
         count_q <= count_n;
         if (clr_ovf_i)
            ovf_q <= 1'b0;
         else if (wr_en_i && fifo_full_o)
            ovf_q <= 1'b1;
         if (pop)
            data_q <= mem[rd_ptr_q];
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (wr_accept)
               wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
               rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept)
         mem[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a uart_tx responder and a character
// scoreboard checked at every start_tx_o request.
module tb_uart_tx_sched;

   localparam int DEPTH    = 16;
   localparam int LVL_W    = $clog2(DEPTH) + 1;
   localparam int ACK_DLY  = 2;
   localparam int DONE_DLY = 10;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             wr_en, flush, tx_en, clr_ovf;
   logic [7:0]       wr_data;
   logic             tx_start_ack, tx_done;
   logic             start_tx;
   logic [31:0]      tx_data;
   logic             fifo_full, fifo_empty, overflow, busy, tx_empty_pulse;
   logic [LVL_W-1:0] fifo_level;

   int checks   = 0;
   int failures = 0;
   int frames   = 0;
   int rises    = 0;
   int pulses   = 0;
   logic ack_hold = 1'b0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   uart_tx_sched #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .wr_en_i          (wr_en),
      .wr_data_i        (wr_data),
      .flush_i          (flush),
      .tx_en_i          (tx_en),
      .clr_ovf_i        (clr_ovf),
      .tx_start_ack_i   (tx_start_ack),
      .tx_done_i        (tx_done),
      .start_tx_o       (start_tx),
      .tx_data_o        (tx_data),
      .fifo_full_o      (fifo_full),
      .fifo_empty_o     (fifo_empty),
      .fifo_level_o     (fifo_level),
      .overflow_o       (overflow),
      .busy_o           (busy),
      .tx_empty_pulse_o (tx_empty_pulse)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // uart_tx model: ack after ACK_DLY cycles (clearing done), done after DONE_DLY more.
   initial begin
      int rstate = 0;
      int cnt    = 0;
      tx_start_ack = 1'b0;
      tx_done      = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            tx_start_ack = 1'b0;
            tx_done      = 1'b1;
            rstate       = 0;
         end else begin
            case (rstate)
               0: if (start_tx) begin cnt = 0; rstate = 1; end
               1: begin
                  if (!start_tx) rstate = 0;
                  else if (!ack_hold) begin
                     cnt++;
                     if (cnt >= ACK_DLY) begin
                        tx_start_ack = 1'b1;
                        tx_done      = 1'b0;
                        frames++;
                        rstate       = 2;
                     end
                  end
               end
               2: begin tx_start_ack = 1'b0; cnt = 0; rstate = 3; end
               default: begin
                  cnt++;
                  if (cnt >= DONE_DLY) begin tx_done = 1'b1; rstate = 0; end
               end
            endcase
         end
      end
   end

   // Scoreboard: every new request must carry the oldest accepted character.
   initial begin
      logic prev = 1'b0;
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (reset_n && start_tx && !prev) begin
            rises++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               check("frame_data", tx_data, {24'h0, exp});
            end
         end
         prev = start_tx;
         if (tx_empty_pulse) pulses++;
      end
   end

   task automatic wr(input logic [7:0] b);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = b;
      if (sb.size() < DEPTH) sb.push_back(b);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_frames(input int n, input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (frames >= n && !busy && !start_tx) break;
      end
      repeat (2) @(negedge clk);
      check(tag, 32'(frames), 32'(n));
   endtask

   task automatic wait_start(input string tag);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (start_tx) break;
      end
      check(tag, {31'h0, start_tx}, 32'd1);
   endtask

   initial begin
      int base;
      reset_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
      tx_en = 1'b0; clr_ovf = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_start", {31'h0, start_tx}, 32'd0);
      check("rst_data", tx_data, 32'd0);
      check("rst_empty", {31'h0, fifo_empty}, 32'd1);
      check("rst_full", {31'h0, fifo_full}, 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_ovf", {31'h0, overflow}, 32'd0);
      check("rst_pulse", {31'h0, tx_empty_pulse}, 32'd0);
      reset_n = 1'b1;

      // single character with latency
      @(negedge clk);
      tx_en = 1'b1; pulses = 0;
      wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
      @(negedge clk);
      wr_en = 1'b0;
      check("t1_empty_n1", {31'h0, fifo_empty}, 32'd0);
      check("t1_start_n1", {31'h0, start_tx}, 32'd0);
      @(negedge clk);
      check("t1_start_n2", {31'h0, start_tx}, 32'd1);
      check("t1_data", tx_data, 32'h0000_00A5);
      wait_frames(1, "t1_frames");
      check("t1_pulses", 32'(pulses), 32'd1);
      check("t1_busy", {31'h0, busy}, 32'd0);

      // burst fill, overflow, clear priority, then drain
      tx_en = 1'b0;
      for (int i = 0; i <= 16; i++) wr(8'(i));
      check("t2_level", 32'(fifo_level), 32'd16);
      check("t2_full", {31'h0, fifo_full}, 32'd1);
      check("t2_ovf", {31'h0, overflow}, 32'd1);
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'h11; clr_ovf = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; clr_ovf = 1'b0;
      check("t2_clr_prio", {31'h0, overflow}, 32'd0);
      check("t2_level2", 32'(fifo_level), 32'd16);
      pulses = 0; base = frames;
      tx_en = 1'b1;
      wait_frames(base + 16, "t2_frames");
      check("t2_pulses", 32'(pulses), 32'd1);
      check("t2_empty", {31'h0, fifo_empty}, 32'd1);
      check("t2_sb", 32'(sb.size()), 32'd0);

      // ack withheld
      ack_hold = 1'b1; pulses = 0; base = frames;
      wr(8'h3C);
      wr(8'h3D);
      wait_start("t3_start");
      repeat (200) @(negedge clk);
      check("t3_hold_start", {31'h0, start_tx}, 32'd1);
      check("t3_hold_data", tx_data, 32'h0000_003C);
      check("t3_hold_level", 32'(fifo_level), 32'd1);
      ack_hold = 1'b0;
      wait_frames(base + 2, "t3_frames");
      check("t3_pulses", 32'(pulses), 32'd1);

      // flush while awaiting ack
      tx_en = 1'b0; ack_hold = 1'b1; base = frames;
      for (int i = 0; i < 6; i++) wr(8'h40 + 8'(i));
      tx_en = 1'b1;
      wait_start("t4_start");
      check("t4_level", 32'(fifo_level), 32'd5);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      sb.delete();
      check("t4_start", {31'h0, start_tx}, 32'd0);
      check("t4_busy", {31'h0, busy}, 32'd0);
      check("t4_level0", 32'(fifo_level), 32'd0);
      repeat (5) @(negedge clk);
      ack_hold = 1'b0;
      repeat (20) @(negedge clk);
      check("t4_no_frame", 32'(frames), 32'(base));

      // simultaneous write and pop, then more traffic across wrap
      tx_en = 1'b0; base = frames;
      for (int i = 0; i < 3; i++) wr(8'h50 + 8'(i));
      @(negedge clk);
      tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'h53; sb.push_back(8'h53);
      @(negedge clk);
      wr_en = 1'b0;
      check("t5_level_same", 32'(fifo_level), 32'd3);
      check("t5_start", {31'h0, start_tx}, 32'd1);
      for (int i = 4; i < 20; i++) begin
         wr(8'h50 + 8'(i));
         repeat (3) @(negedge clk);
      end
      wait_frames(base + 20, "t5_frames");
      check("t5_sb", 32'(sb.size()), 32'd0);

      // asynchronous reset during WAIT_DONE
      tx_en = 1'b0;
      for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
      tx_en = 1'b1;
      wait_start("t6_start");
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy && !start_tx) break;
      end
      check("t6_wait_done", {30'h0, busy, start_tx}, 32'd2);
      check("t6_level", 32'(fifo_level), 32'd4);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_start", {31'h0, start_tx}, 32'd0);
      check("t6_rst_busy", {31'h0, busy}, 32'd0);
      check("t6_rst_level", 32'(fifo_level), 32'd0);
      check("t6_rst_empty", {31'h0, fifo_empty}, 32'd1);
      check("t6_rst_data", tx_data, 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      base = rises;
      repeat (30) @(negedge clk);
      check("t6_no_start", 32'(rises), 32'(base));
      base = frames;
      wr(8'h77);
      wait_frames(base + 1, "t6_new_frame");
      check("t6_rises", 32'(rises), 32'(rises == 0 ? 1 : rises));
      check("t6_sb", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
